// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: sync, glitch filter, 11-bit deframer,
// E0/F0 prefix folding, single-cycle scancode and error pulses.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_ext,
  output logic       o_break,
  output logic       o_err
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] flt;
  logic                  filt;
  logic                  filt_n;
  logic                  fall;
  logic                  bit_in;
  logic [1:0]            state;
  logic [3:0]            bitcnt;
  logic [7:0]            shift;
  logic                  par;
  logic                  ext_pend;
  logic                  brk_pend;
  logic [TW-1:0]         tcnt;
  logic                  tmo;
  logic                  good;

  // Filtered level only moves once the whole window agrees.
  always_comb begin
    filt_n = filt;
    if (flt == '0)
      filt_n = 1'b0;
    else if (&flt)
      filt_n = 1'b1;
  end

  assign fall   = filt & ~filt_n;
  assign bit_in = dat_sync[1];
  assign good   = bit_in & (^shift ^ par);
  assign tmo    = (state != IDLE) &&
                  (tcnt == TO_MAX) && !fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      flt      <= '1;
      filt     <= 1'b1;
      state    <= IDLE;
      bitcnt   <= '0;
      shift    <= '0;
      par      <= 1'b0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      tcnt     <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_ext    <= 1'b0;
      o_break  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], i_ps2_clk};
      dat_sync <= {dat_sync[0], i_ps2_data};
      flt      <= {flt[FILTER_LEN-2:0], clk_sync[1]};
      filt     <= filt_n;
      o_valid  <= 1'b0;
      o_ext    <= 1'b0;
      o_break  <= 1'b0;
      o_err    <= 1'b0;

      if (fall || state == IDLE)
        tcnt <= '0;
      else if (tcnt != '1)
        tcnt <= tcnt + 1'b1;

      if (fall) begin
        unique case (state)
          IDLE: begin
            if (!bit_in) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shift  <= {bit_in, shift[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 4'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= bit_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!good) begin
              o_err    <= 1'b1;
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end else if (shift == 8'hF0) begin
              brk_pend <= 1'b1;
            end else if (shift == 8'hE0) begin
              ext_pend <= 1'b1;
            end else begin
              o_valid  <= 1'b1;
              o_data   <= shift;
              o_ext    <= ext_pend;
              o_break  <= brk_pend;
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end
          end
        endcase
      end else if (tmo) begin
        state    <= IDLE;
        o_err    <= 1'b1;
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 keyboard receiver that replaces the parallel key input and push-button write strobe ahead of the character-write logic feeding the vga text buffer. It synchronises and filters the keyboard clock and data lines, and deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop). It folds E0 (extended) and F0 (break) prefix bytes into flags. Each completed scancode is presented as a one-cycle valid pulse in the gcb_clk domain.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronised samples required before the filtered ps2 clock changes level (min 2)
TIMEOUT, 50000, i_clk cycles without a filtered falling edge before a partial frame is aborted (~2 ms at 25 MHz)

Ports:
i_clk  input  1  system clock (global-buffered pixel clock)
i_rst  input  1  synchronous active-high reset
i_ps2_clk  input  1  raw PS/2 clock line, asynchronous
i_ps2_data  input  1  raw PS/2 data line, asynchronous
o_data  output  8  received scancode, valid while o_valid=1, held afterwards
o_valid  output  1  one-cycle pulse, new scancode on o_data
o_ext  output  1  qualifies o_valid: E0 prefix preceded this code
o_break  output  1  qualifies o_valid: F0 prefix preceded this code (key release)
o_err  output  1  one-cycle pulse on parity, stop or timeout error

Behaviour:
- Reset (i_rst=1 at posedge i_clk):
  - o_data=0, o_valid=0, o_ext=0, o_break=0, o_err=0.
  - State=IDLE; bit count, pending flags and timeout counter cleared.
  - Sync registers and filter shift register preset to 1; filtered clk=1.
  - Reset mid-frame discards the partial frame without an error pulse.
- Synchronisation: both lines pass through 2 flops.
- Filter: a FILTER_LEN-deep shift register samples the synchronised clk.
  - Filtered clk goes to 0 only when all bits are 0, and to 1 only when all bits are 1; otherwise it holds.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Edge detect: fall = filtered_prev & ~filtered. The synchronised data bit is sampled in the same cycle.
- FSM (advances only on fall, except on timeout):
  - IDLE: data=0 -> DATA with bitcnt=0; data=1 -> stay in IDLE, no error.
  - DATA: shift right, new bit into bit 7; bitcnt+1; after the 8th bit -> PARITY.
  - PARITY: store bit -> STOP.
  - STOP: check the frame, then go to IDLE. The frame is good when data=1 and (^shift ^ parity)=1.
- Good frame:
  - Byte F0: set break_pend; no o_valid.
  - Byte E0: set ext_pend; no o_valid.
  - Other bytes: next cycle o_valid=1, o_data=byte, o_ext=ext_pend, o_break=break_pend; both pending flags cleared.
  - o_ext/o_break return to 0 with o_valid.
- Bad frame (parity or stop error): o_err=1 for one cycle, pending flags cleared, o_data unchanged.
- Timeout:
  - The counter clears on every fall and while in IDLE; otherwise it increments.
  - At TIMEOUT-1: state -> IDLE, o_err pulse, pending flags cleared.
- Latency: o_valid/o_err assert exactly 1 i_clk after the fall cycle that samples the stop bit. From the raw stop-bit falling edge this is 2 + FILTER_LEN + 1 cycles.
- Simultaneous events: a fall in the same cycle the counter hits TIMEOUT-1 wins; the bit is processed and there is no timeout.
- o_valid and o_err are never both 1.
- Counter widths: bitcnt 4 bits; timeout counter $clog2(TIMEOUT) bits, saturates, no wrap.
- Device-to-host only: both lines are inputs; no host-to-device transmission.

Test Plan:
- Frame 0x1C (data 0,0,1,1,1,0,0,0; parity 0; stop 1), 20 us/bit -> one o_valid with o_data=1C, o_ext=0, o_break=0, o_err=0; latency 11 cycles after the stop-bit edge (FILTER_LEN=8).
- Frames F0 then 1C -> single o_valid, o_data=1C, o_break=1, o_ext=0. A following 1C -> o_break=0.
- Frames E0, F0, 75 -> single o_valid, o_data=75, o_ext=1, o_break=1.
- Frame 0x1C with parity=1, or with stop=0 -> o_err pulse, no o_valid. Next good frame 0x32 -> o_data=32, flags 0.
- Start + 3 data bits, then clk held high -> o_err exactly TIMEOUT cycles after the last fall, state IDLE. Next full frame 0x5A is received correctly.
- Glitches and reset:
  - 5-cycle low glitch on i_ps2_clk while IDLE -> no state change.
  - i_rst asserted after 4 data bits -> all outputs 0, no o_err; next frame 0x1C is received correctly.
